// File: rtl/jk_bank_driver.sv
// Control stage for a bank of WIDTH JK flip-flops: mirror counter, registered J/K excitation, Q feedback check.
// Optional JK_TOGGLE_EXC_EN selects toggle-form excitation (j = k = cnt ^ target).
module jk_bank_driver #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             err
);

    localparam logic [1:0]       OP_STOP  = 2'b00;
    localparam logic [1:0]       OP_UP    = 2'b01;
    localparam logic [1:0]       OP_DOWN  = 2'b10;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    typedef enum logic [1:0] {
        S_INIT   = 2'd0,
        S_IDLE   = 2'd1,
        S_RUN_UP = 2'd2,
        S_RUN_DN = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] exp_q, exp_q_nxt;
    logic [WIDTH-1:0] j_nxt, k_nxt;
    logic             chk_arm, chk_arm_nxt;
    logic             tc_nxt, err_nxt, ready_nxt;
    logic             accept, step_up, step_dn;

    // State and output registers; reset drives the clear pattern (J=0, K=1) into the bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_INIT;
            cnt       <= '0;
            exp_q     <= '0;
            j         <= '0;
            k         <= ALL_ONES;
            tc        <= 1'b0;
            err       <= 1'b0;
            chk_arm   <= 1'b0;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            exp_q     <= exp_q_nxt;
            j         <= j_nxt;
            k         <= k_nxt;
            tc        <= tc_nxt;
            err       <= err_nxt;
            chk_arm   <= chk_arm_nxt;
            cmd_ready <= ready_nxt;
        end
    end

    // Next state, count target, excitation and check
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        tc_nxt      = 1'b0;
        step_up     = 1'b0;
        step_dn     = 1'b0;
        accept      = cmd_valid & cmd_ready;
        chk_arm_nxt = chk_arm;

        case (state)
            S_INIT: begin
                // The bank clears on this edge; from here on Q must track exp_q
                state_nxt   = S_IDLE;
                chk_arm_nxt = 1'b1;
            end
            default: begin
                if (accept) begin
                    case (cmd_op)
                        OP_STOP: state_nxt = S_IDLE;
                        OP_UP: begin
                            step_up   = 1'b1;
                            state_nxt = S_RUN_UP;
                        end
                        OP_DOWN: begin
                            step_dn   = 1'b1;
                            state_nxt = S_RUN_DN;
                        end
                        default: begin
                            cnt_nxt   = cmd_data;
                            state_nxt = S_IDLE;
                        end
                    endcase
                end else if (state == S_RUN_UP) begin
                    step_up = 1'b1;
                end else if (state == S_RUN_DN) begin
                    step_dn = 1'b1;
                end
            end
        endcase

        if (step_up) begin
            cnt_nxt = cnt + ONE;
            tc_nxt  = (cnt == ALL_ONES);
        end else if (step_dn) begin
            cnt_nxt = cnt - ONE;
            tc_nxt  = (cnt == '0);
        end

`ifdef JK_TOGGLE_EXC_EN
        j_nxt = cnt ^ cnt_nxt;
        k_nxt = cnt ^ cnt_nxt;
`else
        j_nxt = ~cnt & cnt_nxt;
        k_nxt = cnt & ~cnt_nxt;
`endif

        exp_q_nxt = cnt;
        err_nxt   = err | (chk_arm & (q_fb != exp_q));
        ready_nxt = (state_nxt != S_INIT);
    end

    assign count = cnt;

endmodule

// File: tb/tb_jk_bank_driver.sv
// Scoreboard bench for jk_bank_driver: directed commands, behavioural JK bank on q_fb, monitor checks each edge.
module tb_jk_bank_driver;
    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] q_fb, j, k, count;
    logic         cmd_ready, tc, err;
    logic [W-1:0] bank_q = 4'hA;
    logic [W-1:0] fault = '0;

    typedef struct {
        logic [W-1:0] cnt, j, k, q;
        logic         tc, err, rdy;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_chk = 0;
    int   n_pass = 0;

    jk_bank_driver #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .q_fb(q_fb),
        .j(j), .k(k), .count(count), .tc(tc), .err(err)
    );

    always #5 clk = ~clk;

    // Behavioural JK bank (no reset); fault injects a wrong feedback bit
    assign q_fb = bank_q ^ fault;
    always @(posedge clk) begin
        for (int b = 0; b < int'(W); b++) begin
            case ({j[b], k[b]})
                2'b10:   bank_q[b] <= 1'b1;
                2'b01:   bank_q[b] <= 1'b0;
                2'b11:   bank_q[b] <= ~bank_q[b];
                default: bank_q[b] <= bank_q[b];
            endcase
        end
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
    endtask

    // Drive one command, queue the state expected after the next edge, wait to the following negedge
    task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] d,
                        input logic [W-1:0] ec, input logic [W-1:0] ej, input logic [W-1:0] ek,
                        input logic [W-1:0] eq, input bit etc, input bit eerr, input bit erdy);
        exp_t x;
        cmd_valid = v;
        cmd_op    = op;
        cmd_data  = d;
        x.cnt = ec;
        x.q   = eq;
        x.tc  = etc;
        x.err = eerr;
        x.rdy = erdy;
`ifdef JK_TOGGLE_EXC_EN
        x.j = ej | ek;
        x.k = ej | ek;
`else
        x.j = ej;
        x.k = ek;
`endif
        sb.push_back(x);
        @(negedge clk);
    endtask

    // Monitor: one expectation per edge while stimulus is active
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("count", count, e.cnt);
            check("j", j, e.j);
            check("k", k, e.k);
            check("q_fb", bank_q, e.q);
            check("tc", W'(tc), W'(e.tc));
            check("err", W'(err), W'(e.err));
            check("cmd_ready", W'(cmd_ready), W'(e.rdy));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst = 1'b1;
        #1;
        check("rst_j", j, 4'h0);
        check("rst_k", k, 4'hF);
        check("rst_ready", W'(cmd_ready), 4'h0);
        check("rst_count", count, 4'h0);
        check("rst_err", W'(err), 4'h0);
        #1 rst = 1'b0;

        //   v  op     data   cnt    j      k      q      tc err rdy
        step(0, 2'd0, 4'h0,  4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);  // INIT edge clears bank
        step(1, 2'd3, 4'h6,  4'h6, 4'h6, 4'h0, 4'h0, 0, 0, 1);  // LOAD 6
        step(0, 2'd0, 4'h0,  4'h6, 4'h0, 4'h0, 4'h6, 0, 0, 1);
        step(1, 2'd3, 4'hE,  4'hE, 4'h8, 4'h0, 4'h6, 0, 0, 1);  // LOAD E
        step(1, 2'd1, 4'h0,  4'hF, 4'h1, 4'h0, 4'hE, 0, 0, 1);  // UP
        step(0, 2'd0, 4'h0,  4'h0, 4'h0, 4'hF, 4'hF, 1, 0, 1);  // free-run wrap
        step(0, 2'd0, 4'h0,  4'h1, 4'h1, 4'h0, 4'h0, 0, 0, 1);
        step(1, 2'd2, 4'h0,  4'h0, 4'h0, 4'h1, 4'h1, 0, 0, 1);  // DOWN while running up
        step(0, 2'd0, 4'h0,  4'hF, 4'hF, 4'h0, 4'h0, 1, 0, 1);  // down wrap
        step(1, 2'd3, 4'h9,  4'h9, 4'h0, 4'h6, 4'hF, 0, 0, 1);  // LOAD 9 in RUN
        step(0, 2'd0, 4'h0,  4'h9, 4'h0, 4'h0, 4'h9, 0, 0, 1);  // stays IDLE
        step(1, 2'd3, 4'h7,  4'h7, 4'h6, 4'h8, 4'h9, 0, 0, 1);  // LOAD 7
        step(1, 2'd1, 4'h0,  4'h8, 4'h8, 4'h7, 4'h7, 0, 0, 1);  // UP 7->8
        step(1, 2'd0, 4'h0,  4'h8, 4'h0, 4'h0, 4'h8, 0, 0, 1);  // STOP
        fault = 4'h1;
        step(0, 2'd0, 4'h0,  4'h8, 4'h0, 4'h0, 4'h8, 0, 1, 1);  // bad feedback -> err
        fault = 4'h0;
        step(1, 2'd1, 4'h0,  4'h9, 4'h1, 4'h0, 4'h8, 0, 1, 1);  // err sticky
        step(1, 2'd0, 4'h0,  4'h9, 4'h0, 4'h0, 4'h9, 0, 1, 1);

        // Mid-operation reset with a command held on the bus
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_data  = 4'h5;
        rst = 1'b1;
        #1;
        check("rst2_err", W'(err), 4'h0);
        check("rst2_count", count, 4'h0);
        check("rst2_k", k, 4'hF);
        check("rst2_ready", W'(cmd_ready), 4'h0);
        #1 rst = 1'b0;

        step(1, 2'd3, 4'h5,  4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);  // LOAD ignored in INIT
        step(0, 2'd0, 4'h0,  4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);
        step(1, 2'd3, 4'hF,  4'hF, 4'hF, 4'h0, 4'h0, 0, 0, 1);  // LOAD F
        step(1, 2'd1, 4'h0,  4'h0, 4'h0, 4'hF, 4'hF, 1, 0, 1);  // UP command wraps
        step(1, 2'd0, 4'h0,  4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 1);  // STOP
        cmd_valid = 1'b0;

        repeat (3) @(negedge clk);
        n_chk++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
